param_serializer: RTL and testbench

Parametrised successor to the UART TX serializer. It converts a parallel word of up to DATA_WIDTH bits into a bit stream, one bit per enabled cycle. Over the 8-bit fixed block it adds:
- a runtime frame length and bit order (LSB/MSB first);
- a 1-deep holding register with a valid/ready handshake, so frames run back-to-back;
- a stall on ser_en low and a synchronous flush.
It sits between the TX data source and the UART TX FSM/mux, which drives ser_en and consumes ser_data/ser_done.

---
 rtl/serializer_pkg.sv | 14 +
 rtl/ser_bit_counter.sv | 26 ++
 rtl/param_serializer.sv | 110 +++++++++++
 tb/tb_param_serializer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared serializer types and sizing helpers; also used by the UART TX FSM.
package serializer_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ser_state_e;

  // Bit-counter / frame-length width for a given maximum word width.
  function automatic int unsigned cnt_w(input int unsigned dw);
    return (dw < 2) ? 32'd1 : 32'($clog2(dw));
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Per-frame bit counter with clear, restart-from-zero, enable and terminal compare.
module ser_bit_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load_zero,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             at_limit_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr || load_zero) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_limit_c = (cnt == limit);

endmodule

// File: rtl/param_serializer.sv
// Parallel-to-serial converter with runtime frame length/bit order and a
// one-word holding register so consecutive frames run without a gap bit.
module param_serializer
  import serializer_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  localparam int unsigned CNT_W      = cnt_w(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [CNT_W-1:0]      len,
  input  logic                  msb_first,
  input  logic                  flush,
  input  logic                  ser_en,
  output logic                  ser_data,
  output logic                  ser_done,
  output logic                  busy
);

  ser_state_e            state;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [CNT_W-1:0]      hold_len;
  logic                  hold_msb;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      frame_len;
  logic                  frame_msb;

  logic                  active_c;
  logic                  accept_c;
  logic                  last_bit_c;
  logic                  load_c;
  logic                  at_limit_c;
  logic [CNT_W-1:0]      len_clamped_c;

  // Clamp only exists when the len field can encode more than DATA_WIDTH bits.
  if ((1 << CNT_W) > DATA_WIDTH) begin : g_clamp
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(DATA_WIDTH - 1);
    assign len_clamped_c = (len > LEN_MAX) ? LEN_MAX : len;
  end else begin : g_no_clamp
    assign len_clamped_c = len;
  end

  assign active_c   = (state == ACTIVE);
  assign accept_c   = data_valid && !hold_full;
  assign last_bit_c = active_c && ser_en && at_limit_c;
  // Shifter takes the held word when idle, or in the same edge the last bit drains.
  assign load_c     = hold_full && (!active_c || last_bit_c);

  assign data_ready = !hold_full;
  assign busy       = active_c;
  assign ser_data   = active_c && (frame_msb ? shift_reg[frame_len] : shift_reg[0]);
  // An aborted frame never reports completion.
  assign ser_done   = last_bit_c && !flush && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_len  <= '0;
      hold_msb  <= 1'b0;
      shift_reg <= '0;
      frame_len <= '0;
      frame_msb <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      shift_reg <= '0;
    end else begin
      if (accept_c) begin
        hold_data <= p_data;
        hold_len  <= len_clamped_c;
        hold_msb  <= msb_first;
        hold_full <= 1'b1;
      end
      if (load_c) begin
        shift_reg <= hold_data;
        frame_len <= hold_len;
        frame_msb <= hold_msb;
        hold_full <= 1'b0;
        state     <= ACTIVE;
      end else if (active_c && ser_en) begin
        if (at_limit_c) begin
          state <= IDLE;
        end else if (frame_msb) begin
          shift_reg <= shift_reg << 1;
        end else begin
          shift_reg <= shift_reg >> 1;
        end
      end
    end
  end

  ser_bit_counter #(
    .CNT_W(CNT_W)
  ) u_bit_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .load_zero (load_c || last_bit_c),
    .en        (active_c && ser_en),
    .limit     (frame_len),
    .at_limit_c(at_limit_c)
  );

endmodule

// File: tb/tb_param_serializer.sv
// Scoreboard bench: an 8-bit and a 6-bit (len-clamping) instance share one stimulus stream.
module tb_param_serializer;

  localparam int unsigned CW = 3;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, flush, data_valid, msb_first, ser_en;
  logic [7:0]    p_data;
  logic [CW-1:0] len;
  logic          ready_w[2];
  logic          sd_w[2];
  logic          done_w[2];
  logic          busy_w[2];

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit   exp_clear[2];
  bit   exp_nready[2];
  bit   exp_busy_vld[2];
  bit   exp_busy_val[2];
  bit   acc0;
  exp_t mon_e;

  always #5 clk = ~clk;

  param_serializer #(.DATA_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
    .data_ready(ready_w[0]), .len(len), .msb_first(msb_first), .flush(flush),
    .ser_en(ser_en), .ser_data(sd_w[0]), .ser_done(done_w[0]), .busy(busy_w[0])
  );

  param_serializer #(.DATA_WIDTH(6)) u_dut6 (
    .clk(clk), .rst(rst), .p_data(p_data[5:0]), .data_valid(data_valid),
    .data_ready(ready_w[1]), .len(len), .msb_first(msb_first), .flush(flush),
    .ser_en(ser_en), .ser_data(sd_w[1]), .ser_done(done_w[1]), .busy(busy_w[1])
  );

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s [dut%0d] got %0h expected %0h at %0t", nm, k, act, expv, $time);
  endtask

  task automatic fail_now(input string nm, input int k);
    n_checks++;
    $display("FAIL %s [dut%0d] at %0t", nm, k, $time);
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qhead(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  // Reference: a frame is bits 0..L of the word (L clamped to width-1), in the requested order.
  task automatic push_frame(input int k, input logic [7:0] d, input int l, input logic m);
    int   dw;
    int   lc;
    exp_t e;
    dw = (k == 0) ? 8 : 6;
    lc = (l > dw - 1) ? dw - 1 : l;
    for (int i = 0; i <= lc; i++) begin
      e.b    = m ? d[lc - i] : d[i];
      e.last = (i == lc);
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  // One clock: sample readiness before the edge, book accepted words at the edge.
  task automatic tick();
    logic r0, r1;
    @(negedge clk);
    r0 = ready_w[0];
    r1 = ready_w[1];
    @(posedge clk);
    acc0 = 1'b0;
    if (rst || flush) begin
      q0.delete();
      q1.delete();
      exp_clear[0] = 1'b1;
      exp_clear[1] = 1'b1;
    end else begin
      if (data_valid && r0) begin
        push_frame(0, p_data, int'(len), msb_first);
        exp_nready[0] = 1'b1;
        acc0 = 1'b1;
      end
      if (data_valid && r1) begin
        push_frame(1, p_data, int'(len), msb_first);
        exp_nready[1] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int l, input logic m);
    p_data     = d;
    len        = CW'(l);
    msb_first  = m;
    data_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (acc0) break;
    end
    chk("send_accept", 0, acc0, 1);
    data_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (q0.size() == 0 && q1.size() == 0 && !busy_w[0] && !busy_w[1] &&
          ready_w[0] && ready_w[1]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("drain", 0, ok, 1);
  endtask

  // Monitor: compares every consumed bit with the scoreboard and checks state transitions.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (exp_clear[k]) begin
        chk("clear_busy", k, busy_w[k], 0);
        chk("clear_ready", k, ready_w[k], 1);
        chk("clear_data", k, sd_w[k], 0);
        exp_clear[k] = 1'b0;
      end
      if (exp_nready[k]) begin
        chk("ready_after_accept", k, ready_w[k], 0);
        exp_nready[k] = 1'b0;
      end
      if (exp_busy_vld[k]) begin
        chk("busy_next", k, busy_w[k], exp_busy_val[k]);
        exp_busy_vld[k] = 1'b0;
      end
      if (!busy_w[k]) begin
        chk("idle_data", k, sd_w[k], 0);
        chk("idle_done", k, done_w[k], 0);
        if (!rst && !flush && qsize(k) > 0) begin
          exp_busy_vld[k] = 1'b1;
          exp_busy_val[k] = 1'b1;
        end
      end else if (rst || flush) begin
        chk("abort_done", k, done_w[k], 0);
      end else if (qsize(k) == 0) begin
        fail_now("unexpected_active", k);
      end else if (!ser_en) begin
        mon_e = qhead(k);
        chk("stall_data", k, sd_w[k], mon_e.b);
        chk("stall_done", k, done_w[k], 0);
        exp_busy_vld[k] = 1'b1;
        exp_busy_val[k] = 1'b1;
      end else begin
        if (k == 0) mon_e = q0.pop_front();
        else mon_e = q1.pop_front();
        chk("bit", k, sd_w[k], mon_e.b);
        chk("done", k, done_w[k], mon_e.last);
        exp_busy_vld[k] = 1'b1;
        exp_busy_val[k] = !mon_e.last || (qsize(k) > 0);
      end
    end
  end

  initial begin
    logic [3:0] pat;
    rst        = 1'b1;
    flush      = 1'b0;
    data_valid = 1'b0;
    ser_en     = 1'b1;
    p_data     = 8'h00;
    len        = '0;
    msb_first  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    send(8'hC1, 7, 1'b0); drain();
    send(8'hC1, 7, 1'b1); drain();
    send(8'h0A, 3, 1'b0); drain();
    send(8'h0F, 7, 1'b0); send(8'hF0, 7, 1'b0); drain();

    // Enable pattern 1,0,0,1 repeating during a frame.
    pat = 4'b1001;
    send(8'hC1, 7, 1'b0);
    for (int c = 0; c < 40; c++) begin
      ser_en = pat[c % 4];
      tick();
    end
    ser_en = 1'b1;
    drain();

    send(8'hC1, 7, 1'b1); drain();
    send(8'hA5, 6, 1'b0); drain();
    for (int i = 0; i < 6; i++) send(8'h01, 0, 1'b0);
    drain();

    // Abort with a word waiting in the holding register: flush, then reset.
    for (int pass = 0; pass < 2; pass++) begin
      send(8'hC1, 7, 1'b0);
      send(8'h3C, 5, 1'b1);
      tick(); tick();
      p_data     = 8'hAA;
      data_valid = 1'b1;
      if (pass == 0) flush = 1'b1;
      else rst = 1'b1;
      tick();
      flush      = 1'b0;
      rst        = 1'b0;
      data_valid = 1'b0;
      tick(); tick();
      send(8'h5A, 7, 1'b0);
      drain();
    end

    // Randomised traffic; the source holds a word until the 8-bit instance takes it.
    for (int c = 0; c < 3000; c++) begin
      if (!data_valid || acc0) begin
        data_valid = ($urandom_range(0, 2) != 0);
        p_data     = 8'($urandom);
        len        = CW'($urandom_range(0, 7));
        msb_first  = 1'($urandom_range(0, 1));
      end
      ser_en = ($urandom_range(0, 3) != 0);
      flush  = ($urandom_range(0, 79) == 0);
      rst    = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst        = 1'b0;
    flush      = 1'b0;
    data_valid = 1'b0;
    ser_en     = 1'b1;
    drain();
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
